vbus_mem_target: RTL and testbench

- Responder (target) end of the simple system bus driven by the VJTAG host: address, wvalid/wdata/wready, rvalid/rready, and rrvalid/rdata.
- Backs the bus with an on-chip word memory.
- Has programmable write wait states and read latency, so host and bench software can exercise stall, backpressure and response paths before the SDRAM controller is attached.
- Sits on the clk domain, directly on the host's bus port.

---
 rtl/vbus_mem_target_if.sv | 26 ++
 rtl/vbus_mem_target.sv | 125 ++++++++++++
 tb/tb_vbus_mem_target.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vbus_mem_target_if.sv
// Simple system bus between the VJTAG host (master) and a memory target (slave).
// Carries the write request/accept pair, the read request/accept pair and the
// one-cycle read response strobe with its data.
interface vbus_mem_target_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic [AW-1:0] address;
    logic          wvalid;
    logic [DW-1:0] wdata;
    logic          wready;
    logic          rvalid;
    logic          rready;
    logic          rrvalid;
    logic [DW-1:0] rdata;

    modport master (
        output address, wvalid, wdata, rvalid,
        input  wready, rready, rrvalid, rdata
    );

    modport slave (
        input  address, wvalid, wdata, rvalid,
        output wready, rready, rrvalid, rdata
    );
endinterface

// File: rtl/vbus_mem_target.sv
// Memory-backed bus target with programmable write wait states and read latency.
// Optional macro VBUS_TGT_BOUNDS_EN: addresses at or above 2**DEPTH_LOG2 are
// treated as out of range (writes dropped, reads return all ones) instead of
// aliasing onto the low index bits. Handshake timing is identical either way.
//
// state | meaning
// IDLE  | no transaction in progress
// WWAIT | counting write wait states before wready
// RLAT  | counting read latency before the rrvalid strobe
module vbus_mem_target #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int WR_WAIT    = 2,
    parameter int RD_LAT     = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    vbus_mem_target_if.slave bus
);

    if (AW < DEPTH_LOG2) begin : g_bad_aw
        $error("vbus_mem_target: AW must be >= DEPTH_LOG2");
    end
    if ((WR_WAIT < 0) || (WR_WAIT > 15)) begin : g_bad_wr_wait
        $error("vbus_mem_target: WR_WAIT must be in 0..15");
    end
    if ((RD_LAT < 1) || (RD_LAT > 15)) begin : g_bad_rd_lat
        $error("vbus_mem_target: RD_LAT must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, WWAIT, RLAT} state_t;

    // Counter load values; the WR_WAIT==0 case never enters WWAIT.
    localparam logic [3:0] WR_CNT0 = 4'((WR_WAIT > 0) ? (WR_WAIT - 1) : 0);
    localparam logic [3:0] RD_CNT0 = 4'(RD_LAT - 1);

    state_t                state;
    logic [3:0]            cnt;
    logic [DW-1:0]         rd_buf;
    logic [DW-1:0]         rdata_q;
    logic                  rrvalid_q;
    logic [DW-1:0]         rd_word;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  wr_commit;
    logic [DW-1:0]         mem [2**DEPTH_LOG2];

    assign idx = bus.address[DEPTH_LOG2-1:0];

    // Accepts are combinational so zero-wait writes and reads complete in one cycle;
    // both are forced low while reset is asserted.
    assign bus.wready = rst_n && bus.wvalid &&
                        (((state == IDLE) && (WR_WAIT == 0)) ||
                         ((state == WWAIT) && (cnt == 4'd0)));
    assign bus.rready = rst_n && (state == IDLE) && bus.rvalid && !bus.wvalid;

    assign wr_commit   = bus.wvalid && bus.wready;
    assign bus.rrvalid = rrvalid_q;
    assign bus.rdata   = rdata_q;

`ifdef VBUS_TGT_BOUNDS_EN
    logic in_range;
    assign in_range = ((bus.address >> DEPTH_LOG2) == '0);
    assign rd_word  = in_range ? mem[idx] : {DW{1'b1}};
`else
    assign rd_word  = mem[idx];
`endif

    // Memory array; contents survive reset.
    always_ff @(posedge clk) begin
`ifdef VBUS_TGT_BOUNDS_EN
        if (wr_commit && in_range) begin
`else
        if (wr_commit) begin
`endif
            mem[idx] <= bus.wdata;
        end
    end

    // Sequencing FSM: write wait-state and read latency countdowns, response strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rd_buf    <= '0;
            rrvalid_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rrvalid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wvalid) begin
                        if (WR_WAIT != 0) begin
                            state <= WWAIT;
                            cnt   <= WR_CNT0;
                        end
                    end else if (bus.rvalid) begin
                        rd_buf <= rd_word;
                        cnt    <= RD_CNT0;
                        state  <= RLAT;
                    end
                end
                WWAIT: begin
                    // A dropped wvalid abandons the write without touching memory.
                    if (!bus.wvalid || (cnt == 4'd0)) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RLAT: begin
                    if (cnt == 4'd0) begin
                        rrvalid_q <= 1'b1;
                        rdata_q   <= rd_buf;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vbus_mem_target.sv
module tb_vbus_mem_target;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    vbus_mem_target_if #(.AW(16), .DW(16)) bus_a ();
    vbus_mem_target_if #(.AW(16), .DW(16)) bus_b ();

    // Default timing: WR_WAIT=2, RD_LAT=2
    vbus_mem_target #(
        .AW(16), .DW(16), .DEPTH_LOG2(8), .WR_WAIT(2), .RD_LAT(2)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    // Zero-wait timing: WR_WAIT=0, RD_LAT=1
    vbus_mem_target #(
        .AW(16), .DW(16), .DEPTH_LOG2(8), .WR_WAIT(0), .RD_LAT(1)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          sel;
        bit          is_wr;
        logic [15:0] addr;
        logic [15:0] data;
        int          exp_time;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input bit sel, input logic wv, input logic rv,
                         input logic [15:0] a, input logic [15:0] d);
        if (sel) begin
            bus_b.wvalid = wv; bus_b.rvalid = rv; bus_b.address = a; bus_b.wdata = d;
        end else begin
            bus_a.wvalid = wv; bus_a.rvalid = rv; bus_a.address = a; bus_a.wdata = d;
        end
    endtask

    function automatic logic get_wready(input bit sel);
        return sel ? bus_b.wready : bus_a.wready;
    endfunction
    function automatic logic get_rready(input bit sel);
        return sel ? bus_b.rready : bus_a.rready;
    endfunction
    function automatic logic get_rrvalid(input bit sel);
        return sel ? bus_b.rrvalid : bus_a.rrvalid;
    endfunction
    function automatic logic [15:0] get_rdata(input bit sel);
        return sel ? bus_b.rdata : bus_a.rdata;
    endfunction

    // Write; exp_cyc is the cycle (from first wvalid cycle = 0) where wready first rises.
    task automatic do_write(input bit sel, input logic [15:0] a, input logic [15:0] d,
                            input int exp_cyc);
        int cyc;
        cyc = -1;
        @(negedge clk);
        drive(sel, 1'b1, 1'b0, a, d);
        for (int c = 0; c < 20; c++) begin
            #1;
            if (get_wready(sel)) begin
                cyc = c;
                break;
            end
            @(negedge clk);
        end
        chk("wr_ready_cycle", cyc, exp_cyc);
        if (cyc >= 0) @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, a, d);
        #1;
        chk("wr_ready_drop", {31'd0, get_wready(sel)}, 32'd0);
    endtask

    // Read; checks accept in cycle 0, edges from accept to rrvalid, data, one-cycle strobe, hold.
    task automatic do_read(input bit sel, input logic [15:0] a, input logic [15:0] exp_data,
                           input int exp_lat);
        int lat;
        lat = -1;
        @(negedge clk);
        drive(sel, 1'b0, 1'b1, a, 16'h0000);
        #1;
        chk("rd_accept", {31'd0, get_rready(sel)}, 32'd1);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, a, 16'h0000);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (get_rrvalid(sel)) begin
                lat = n;
                break;
            end
        end
        chk("rd_latency", lat, exp_lat);
        chk("rd_data", {16'd0, get_rdata(sel)}, {16'd0, exp_data});
        @(posedge clk);
        #1;
        chk("rd_strobe_width", {31'd0, get_rrvalid(sel)}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rd_data_hold", {16'd0, get_rdata(sel)}, {16'd0, exp_data});
    endtask

    initial begin
        int  cnt_rr;
        n_total = 0;
        n_pass  = 0;

        vecs[0]  = '{1'b0, 1'b1, 16'h0012, 16'hBEEF, 2};
        vecs[1]  = '{1'b0, 1'b0, 16'h0012, 16'hBEEF, 2};
        vecs[2]  = '{1'b0, 1'b1, 16'h0034, 16'h00C3, 2};
        vecs[3]  = '{1'b0, 1'b1, 16'h00FF, 16'h7E81, 2};
        vecs[4]  = '{1'b0, 1'b0, 16'h0034, 16'h00C3, 2};
        vecs[5]  = '{1'b0, 1'b0, 16'h00FF, 16'h7E81, 2};
        vecs[6]  = '{1'b0, 1'b1, 16'h0000, 16'h0A0A, 2};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0A0A, 2};
        vecs[8]  = '{1'b1, 1'b1, 16'h0001, 16'h0011, 0};
        vecs[9]  = '{1'b1, 1'b1, 16'h0002, 16'h0022, 0};
        vecs[10] = '{1'b1, 1'b0, 16'h0001, 16'h0011, 1};
        vecs[11] = '{1'b1, 1'b0, 16'h0002, 16'h0022, 1};

        // Reset state, with requests already pending on the zero-wait target
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b1, 1'b1, 16'h0001, 16'h5A5A);
        #3;
        chk("rst_wready", {31'd0, bus_b.wready}, 32'd0);
        chk("rst_rready", {31'd0, bus_b.rready}, 32'd0);
        chk("rst_rrvalid", {31'd0, bus_a.rrvalid}, 32'd0);
        chk("rst_rdata", {16'd0, bus_a.rdata}, 32'd0);
        repeat (2) @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].sel, vecs[i].addr, vecs[i].data, vecs[i].exp_time);
            else
                do_read(vecs[i].sel, vecs[i].addr, vecs[i].data, vecs[i].exp_time);
        end

        // Back-to-back zero-wait writes with wvalid held across both
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 16'h0003, 16'h0033);
        #1;
        chk("b2b_wready0", {31'd0, bus_b.wready}, 32'd1);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 16'h0004, 16'h0044);
        #1;
        chk("b2b_wready1", {31'd0, bus_b.wready}, 32'd1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        do_read(1'b1, 16'h0003, 16'h0033, 1);
        do_read(1'b1, 16'h0004, 16'h0044, 1);

        // Simultaneous write and read: write wins, read then sees new data
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 16'h0005, 16'hAAAA);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("sim_wready", {31'd0, bus_a.wready}, (c == 2) ? 32'd1 : 32'd0);
            chk("sim_rready", {31'd0, bus_a.rready}, 32'd0);
            @(negedge clk);
        end
        bus_a.wvalid = 1'b0;
        #1;
        chk("sim_rready_after", {31'd0, bus_a.rready}, 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000);
        cnt_rr = -1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (bus_a.rrvalid) begin
                cnt_rr = n;
                break;
            end
        end
        chk("sim_rd_latency", cnt_rr, 2);
        chk("sim_rd_data", {16'd0, bus_a.rdata}, 32'h0000AAAA);

        // Reset while the read is in its latency window
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 16'h0012, 16'h0000);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 16'h0012, 16'h0000);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 16'h0012, 16'h0000);
        #1;
        chk("mid_rst_rdata", {16'd0, bus_a.rdata}, 32'd0);
        chk("mid_rst_rrvalid", {31'd0, bus_a.rrvalid}, 32'd0);
        chk("mid_rst_rready", {31'd0, bus_a.rready}, 32'd0);
        cnt_rr = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus_a.rrvalid) cnt_rr++;
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus_a.rrvalid) cnt_rr++;
        end
        chk("mid_rst_no_strobe", cnt_rr, 0);
        chk("mid_rst_rdata_after", {16'd0, bus_a.rdata}, 32'd0);
        do_read(1'b0, 16'h0012, 16'hBEEF, 2);

`ifdef VBUS_TGT_BOUNDS_EN
        // Out-of-range write dropped with normal timing; out-of-range read returns ones
        do_write(1'b0, 16'h0100, 16'h5555, 2);
        do_read(1'b0, 16'h0000, 16'h0A0A, 2);
        do_read(1'b0, 16'h0100, 16'hFFFF, 2);
`else
        // Upper address bits alias onto the same word
        do_write(1'b0, 16'h0112, 16'h1234, 2);
        do_read(1'b0, 16'h0012, 16'h1234, 2);
        do_read(1'b0, 16'h0000, 16'h0A0A, 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
